wb_register_file: RTL and testbench

//  Write-back stage and architectural register file; sits directly downstream of the MEM/WB pipeline register.

---
 rtl/wb_register_file.sv | 71 +++++++
 tb/tb_wb_register_file.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wb_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : wb_register_file
//  Purpose  : Write-back result select plus 16-entry architectural register
//             file with three bypassed read ports; R15 doubles as the PC.
//  Revision : 1.0  initial release
// ============================================================================
module wb_register_file #(
    parameter int DW   = 32,
    parameter int NREG = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_inst,
    input  logic          rf_en,
    input  logic [3:0]    rd,
    input  logic [DW-1:0] load_data,
    input  logic [DW-1:0] nonload_data,
    input  logic [DW-1:0] pc_in,
    input  logic          pc_ld,
    input  logic [3:0]    ra,
    input  logic [3:0]    rb,
    input  logic [3:0]    rc,
    output logic [DW-1:0] pa,
    output logic [DW-1:0] pb,
    output logic [DW-1:0] pc,
    output logic [DW-1:0] wb_data,
    output logic          wb_valid,
    output logic [DW-1:0] pc_out
);

    localparam logic [3:0] c_PC_IDX = 4'd15;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    assign wb_data  = load_inst ? load_data : nonload_data;
    assign wb_valid = rf_en;

    // The WB write is applied after the PC load so it wins on R15.
    always_comb begin
        regs_d = regs_q;
        if (pc_ld) begin
            regs_d[c_PC_IDX] = pc_in;
        end
        if (rf_en) begin
            regs_d[rd] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass is suppressed under reset since no write will land that cycle.
    logic w_byp_ok;
    assign w_byp_ok = rf_en && !reset;

    assign pa     = (w_byp_ok && (ra == rd)) ? wb_data : regs_q[ra];
    assign pb     = (w_byp_ok && (rb == rd)) ? wb_data : regs_q[rb];
    assign pc     = (w_byp_ok && (rc == rd)) ? wb_data : regs_q[rc];
    assign pc_out = regs_q[c_PC_IDX];

endmodule
`default_nettype wire

// File: tb/tb_wb_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_register_file
//  Purpose  : Self-checking bench for wb_register_file against an array model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_register_file;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, load_inst, rf_en, pc_ld;
    logic [3:0]    rd, ra, rb, rc;
    logic [DW-1:0] load_data, nonload_data, pc_in;
    logic [DW-1:0] pa, pb, pc, wb_data, pc_out;
    logic          wb_valid;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mdl [16];

    always #5 clk = ~clk;

    wb_register_file #(.DW(DW), .NREG(16)) u_dut (
        .clk(clk), .reset(reset), .load_inst(load_inst), .rf_en(rf_en),
        .rd(rd), .load_data(load_data), .nonload_data(nonload_data),
        .pc_in(pc_in), .pc_ld(pc_ld), .ra(ra), .rb(rb), .rc(rc),
        .pa(pa), .pb(pb), .pc(pc), .wb_data(wb_data), .wb_valid(wb_valid),
        .pc_out(pc_out)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] sel_wb();
        return load_inst ? load_data : nonload_data;
    endfunction

    // A read sees the value being written this cycle, or the stored value.
    function automatic logic [DW-1:0] exp_rd(input logic [3:0] a);
        if (!reset && rf_en && a == rd) return sel_wb();
        return mdl[a];
    endfunction

    task automatic check_now();
        chk("wb_data",  wb_data,        sel_wb());
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, rf_en});
        chk("pa",       pa,             exp_rd(ra));
        chk("pb",       pb,             exp_rd(rb));
        chk("pc",       pc,             exp_rd(rc));
        chk("pc_out",   pc_out,         mdl[15]);
    endtask

    // Check combinational outputs mid-cycle, then clock and update the model.
    task automatic tick();
        #2;
        check_now();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) mdl[i] = '0;
        end else begin
            if (pc_ld) mdl[15] = pc_in;
            if (rf_en) mdl[rd] = sel_wb();
        end
        #1;
    endtask

    task automatic idle();
        reset = 0; rf_en = 0; pc_ld = 0; load_inst = 0; rd = 0;
        load_data = 0; nonload_data = 0; pc_in = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = 'x;
        idle();
        ra = 0; rb = 0; rc = 0;
        @(posedge clk); #1;

        // Reset overrides write and PC load
        reset = 1; rf_en = 1; rd = 3; pc_ld = 1; pc_in = 32'h55; nonload_data = 32'h77;
        ra = 3; rb = 15; rc = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        tick();
        chk("rst_r3",  pa,     32'h0);
        chk("rst_r15", pc_out, 32'h0);
        idle();
        tick();

        // Load select
        rf_en = 1; rd = 5; load_inst = 1; load_data = 32'hDEADBEEF; nonload_data = 32'h1;
        tick();
        idle(); ra = 5; #1;
        chk("r5_load", pa, 32'hDEADBEEF);
        rf_en = 1; rd = 5; load_inst = 0; load_data = 32'hDEADBEEF; nonload_data = 32'h1;
        tick();
        idle(); ra = 5; #1;
        chk("r5_nonload", pa, 32'h1);

        // Bypass on all three ports
        rf_en = 1; rd = 7; nonload_data = 32'h12345678; ra = 7; rb = 7; rc = 7;
        #2;
        chk("byp_pa", pa, 32'h12345678);
        chk("byp_pb", pb, 32'h12345678);
        chk("byp_pc", pc, 32'h12345678);
        tick();

        // Write disabled
        idle(); rd = 2; nonload_data = 32'hFFFFFFFF; ra = 2;
        #2;
        chk("nowr_pa", pa, 32'h0);
        chk("nowr_valid", {31'd0, wb_valid}, 32'h0);
        tick();
        chk("nowr_r2", pa, 32'h0);

        // R15 priority
        pc_ld = 1; pc_in = 32'h100; rf_en = 1; rd = 15; nonload_data = 32'h200;
        tick();
        chk("r15_wb", pc_out, 32'h200);
        rf_en = 0; pc_in = 32'h104;
        tick();
        chk("r15_pcld", pc_out, 32'h104);
        pc_ld = 0; pc_in = 32'h999;
        tick();
        chk("r15_hold", pc_out, 32'h104);

        // Sweep R0..R14
        idle();
        for (int i = 0; i < 15; i++) begin
            rf_en = 1; rd = 4'(i); nonload_data = 32'hA0 + 32'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 15; i++) begin
            ra = 4'(i); rb = 4'(14 - i); rc = 4'(i);
            #1;
            chk("sweep_pa", pa, 32'hA0 + 32'(i));
            chk("sweep_pb", pb, 32'hA0 + 32'(14 - i));
            chk("sweep_pc", pc, 32'hA0 + 32'(i));
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 39) == 0);
            rf_en        = $urandom_range(0, 3) != 0;
            pc_ld        = $urandom_range(0, 1) == 1;
            load_inst    = $urandom_range(0, 1) == 1;
            rd           = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            load_data    = $urandom;
            nonload_data = $urandom;
            pc_in        = $urandom;
            ra = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, 15));
            rc = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
